// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache tag controller.
// Defines tag-store entry layout, bit-enable masks and the FSM state enum.
package dcache_pkg;

    localparam int unsigned DCACHE_ADDR_WIDTH   = 64;
    localparam int unsigned DCACHE_NUM_WORDS    = 256;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned DCACHE_INDEX_WIDTH  =
        $clog2(DCACHE_NUM_WORDS);
    localparam int unsigned DCACHE_TAG_WIDTH    =
        DCACHE_ADDR_WIDTH - DCACHE_OFFSET_WIDTH
        - DCACHE_INDEX_WIDTH;

    localparam int unsigned DCACHE_TAG_STORE_DATA_WIDTH =
        DCACHE_TAG_WIDTH + 2;

    // Entry layout: {valid, dirty, tag}
    localparam int unsigned DCACHE_VALID_BIT = DCACHE_TAG_WIDTH + 1;
    localparam int unsigned DCACHE_DIRTY_BIT = DCACHE_TAG_WIDTH;

    typedef logic [DCACHE_TAG_STORE_DATA_WIDTH-1:0]
        tag_store_data_t;
    typedef logic [DCACHE_TAG_STORE_DATA_WIDTH-1:0]
        tag_store_bit_enable_t;

    localparam tag_store_bit_enable_t DCACHE_BE_ALL = '1;
    localparam tag_store_bit_enable_t DCACHE_BE_DIRTY =
        tag_store_bit_enable_t'(1) << DCACHE_DIRTY_BIT;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_WB_REQ,
        ST_WB_WAIT,
        ST_RF_REQ,
        ST_RF_WAIT,
        ST_UPDATE
    } dcache_tag_ctrl_state_e;

endpackage

// File: rtl/dcache_tag_ctrl.sv
// Tag lookup/update controller in front of the dcache tag store.
// Ports: clk_i/rst_ni; CPU req (valid/ready/addr/we) and rsp
// (valid/hit); miss-unit req (valid/ready/wb/addr) and done pulse;
// tag-store en/we/addr/wdata/bit_en out and rdata in.
module dcache_tag_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DCACHE_ADDR_WIDTH,
    parameter int unsigned NUM_WORDS    = DCACHE_NUM_WORDS,
    parameter int unsigned OFFSET_WIDTH = DCACHE_OFFSET_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_WIDTH-1:0]        req_addr_i,
    input  logic                         req_we_i,
    output logic                         rsp_valid_o,
    output logic                         rsp_hit_o,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic                         mem_req_wb_o,
    output logic [ADDR_WIDTH-1:0]        mem_req_addr_o,
    input  logic                         mem_done_i,
    output logic                         ts_en_o,
    output logic                         ts_we_o,
    output logic [$clog2(NUM_WORDS)-1:0] ts_addr_o,
    output tag_store_data_t              ts_wdata_o,
    output tag_store_bit_enable_t        ts_bit_en_o,
    input  tag_store_data_t              ts_rdata_i
);

    localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
    localparam int unsigned TAG_WIDTH =
        ADDR_WIDTH - OFFSET_WIDTH - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    dcache_tag_ctrl_state_e state_q, state_d;

    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [TAG_WIDTH-1:0] vtag_q, vtag_d;
    logic                 we_q, we_d;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_WIDTH-1:0] req_tag;
    logic [TAG_WIDTH-1:0] rd_tag;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic                 hit;
    logic                 unused_offset;

    assign req_idx  = req_addr_i[OFFSET_WIDTH +: IDX_W];
    assign req_tag  = req_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign rd_tag   = ts_rdata_i[TAG_WIDTH-1:0];
    assign rd_valid = ts_rdata_i[DCACHE_VALID_BIT];
    assign rd_dirty = ts_rdata_i[DCACHE_DIRTY_BIT];
    assign hit      = rd_valid && (rd_tag == tag_q);

    // Byte offset never reaches the tag store or the miss unit.
    assign unused_offset = ^req_addr_i[OFFSET_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            vtag_q  <= vtag_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        tag_d           = tag_q;
        vtag_d          = vtag_q;
        we_d            = we_q;
        req_ready_o     = 1'b0;
        rsp_valid_o     = 1'b0;
        rsp_hit_o       = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_wb_o    = 1'b0;
        mem_req_addr_o  = '0;
        ts_en_o         = 1'b0;
        ts_we_o         = 1'b0;
        ts_addr_o       = idx_q;
        ts_wdata_o      = '0;
        ts_bit_en_o     = '0;

        unique case (state_q)
            ST_INIT: begin
                ts_en_o     = 1'b1;
                ts_we_o     = 1'b1;
                ts_addr_o   = cnt_q;
                ts_bit_en_o = DCACHE_BE_ALL;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    ts_en_o   = 1'b1;
                    ts_addr_o = req_idx;
                    idx_d     = req_idx;
                    tag_d     = req_tag;
                    we_d      = req_we_i;
                    state_d   = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    rsp_valid_o = 1'b1;
                    rsp_hit_o   = 1'b1;
                    state_d     = ST_IDLE;
                    // Store hit only touches the dirty bit.
                    if (we_q) begin
                        ts_en_o     = 1'b1;
                        ts_we_o     = 1'b1;
                        ts_bit_en_o = DCACHE_BE_DIRTY;
                        ts_wdata_o[DCACHE_DIRTY_BIT] = 1'b1;
                    end
                end else begin
                    vtag_d = rd_tag;
                    if (rd_valid && rd_dirty) begin
                        state_d = ST_WB_REQ;
                    end else begin
                        state_d = ST_RF_REQ;
                    end
                end
            end
            ST_WB_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_wb_o    = 1'b1;
                mem_req_addr_o  =
                    {vtag_q, idx_q, {OFFSET_WIDTH{1'b0}}};
                if (mem_req_ready_i) begin
                    state_d = ST_WB_WAIT;
                end
            end
            ST_WB_WAIT: begin
                if (mem_done_i) begin
                    state_d = ST_RF_REQ;
                end
            end
            ST_RF_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  =
                    {tag_q, idx_q, {OFFSET_WIDTH{1'b0}}};
                if (mem_req_ready_i) begin
                    state_d = ST_RF_WAIT;
                end
            end
            ST_RF_WAIT: begin
                if (mem_done_i) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                ts_en_o     = 1'b1;
                ts_we_o     = 1'b1;
                ts_bit_en_o = DCACHE_BE_ALL;
                ts_wdata_o  = {1'b1, we_q, tag_q};
                rsp_valid_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Self-checking bench for dcache_tag_ctrl with a behavioural
// tag store (negedge read, posedge bit-masked write).
module tb_dcache_tag_ctrl;
    import dcache_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [63:0]           req_addr;
    logic                  req_we;
    logic                  rsp_valid;
    logic                  rsp_hit;
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_wb;
    logic [63:0]           mem_addr;
    logic                  mem_done;
    logic                  ts_en;
    logic                  ts_we;
    logic [7:0]            ts_addr;
    tag_store_data_t       ts_wdata;
    tag_store_bit_enable_t ts_bit_en;
    tag_store_data_t       ts_rdata;

    tag_store_data_t mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [63:0] V = 64'h0020_0000_0000_0000;
    localparam logic [63:0] D = 64'h0010_0000_0000_0000;

    always #5 clk = ~clk;

    dcache_tag_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_we_i        (req_we),
        .rsp_valid_o     (rsp_valid),
        .rsp_hit_o       (rsp_hit),
        .mem_req_valid_o (mem_valid),
        .mem_req_ready_i (mem_ready),
        .mem_req_wb_o    (mem_wb),
        .mem_req_addr_o  (mem_addr),
        .mem_done_i      (mem_done),
        .ts_en_o         (ts_en),
        .ts_we_o         (ts_we),
        .ts_addr_o       (ts_addr),
        .ts_wdata_o      (ts_wdata),
        .ts_bit_en_o     (ts_bit_en),
        .ts_rdata_i      (ts_rdata)
    );

    always @(negedge clk) begin
        if (ts_en && !ts_we) ts_rdata <= mem[ts_addr];
    end

    always @(posedge clk) begin
        if (ts_en && ts_we)
            mem[ts_addr] <= (mem[ts_addr] & ~ts_bit_en)
                          | (ts_wdata & ts_bit_en);
    end

    typedef struct {
        logic [63:0] addr;
        logic        we;
        int          dly;
        logic        hit;
        logic        wb;
        logic [63:0] wb_addr;
        logic [63:0] rf_addr;
        logic [63:0] entry;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Entered at +1 of a request cycle; leaves at +1 of the
    // state after the matching wait state.
    task automatic mem_phase(input string id, input logic wb,
                             input logic [63:0] a, input int dly);
        for (int k = 0; k <= dly; k++) begin
            mem_ready = (k == dly);
            #1;
            chk({id, " req_valid"}, mem_valid, 1);
            chk({id, " req_wb"}, mem_wb, wb);
            chk({id, " req_addr"}, mem_addr, a);
            step;
        end
        mem_ready = 1'b0;
        #1;
        chk({id, " wait idle"}, {mem_valid, ts_en}, 0);
        step;
        mem_done = 1'b1;
        step;
        mem_done = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string id;
        id = $sformatf("v%0d", n);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        #1;
        chk({id, " ready"}, req_ready, 1);
        step;
        req_valid = 1'b0;
        #1;
        chk({id, " lookup rsp"}, rsp_valid, v.hit);
        if (v.hit) begin
            chk({id, " hit"}, rsp_hit, 1);
            chk({id, " no mem req"}, mem_valid, 0);
            chk({id, " hit ts_we"}, ts_we, v.we);
            if (v.we)
                chk({id, " dirty be"}, ts_bit_en, DCACHE_BE_DIRTY);
        end else begin
            step;
            if (v.wb) mem_phase({id, " wb"}, 1'b1, v.wb_addr, v.dly);
            mem_phase({id, " rf"}, 1'b0, v.rf_addr, v.dly);
            #1;
            chk({id, " upd rsp"}, {rsp_valid, rsp_hit}, 2'b10);
            chk({id, " upd we"}, ts_we, 1);
            chk({id, " upd be"}, ts_bit_en, DCACHE_BE_ALL);
        end
        step;
        #1;
        chk({id, " entry"}, mem[v.addr[11:4]], v.entry);
        chk({id, " ready after"}, req_ready, 1);
    endtask

    // Entered at +1 just after rst_n rises.
    task automatic wait_init(input string id);
        int n;
        n = 0;
        #1;
        chk({id, " sweep start"}, ts_addr, 0);
        while (!req_ready && n < 1000) begin
            n++;
            step;
            #1;
        end
        chk({id, " init cycles"}, n, 256);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    initial begin
        int bad;
        vecs[0] = '{64'h8000_1040, 0, 0, 0, 0, 64'h0,
                    64'h8000_1040, V | 64'h80001};
        vecs[1] = '{64'h8000_1040, 0, 0, 1, 0, 64'h0,
                    64'h0, V | 64'h80001};
        vecs[2] = '{64'h8000_1048, 1, 0, 1, 0, 64'h0,
                    64'h0, V | D | 64'h80001};
        vecs[3] = '{64'h9000_1040, 0, 5, 0, 1, 64'h8000_1040,
                    64'h9000_1040, V | 64'h90001};
        vecs[4] = '{64'h1234_567C, 1, 1, 0, 0, 64'h0,
                    64'h1234_5670, V | D | 64'h12345};
        vecs[5] = '{64'h1234_5674, 0, 0, 1, 0, 64'h0,
                    64'h0, V | D | 64'h12345};
        vecs[6] = '{64'h5234_5670, 0, 0, 0, 1, 64'h1234_5670,
                    64'h5234_5670, V | 64'h52345};
        vecs[7] = '{64'h9000_1040, 0, 0, 1, 0, 64'h0,
                    64'h0, V | 64'h90001};

        for (int i = 0; i < 256; i++) mem[i] = '1;
        ts_rdata  = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        mem_ready = 1'b0;
        mem_done  = 1'b0;

        step;
        step;
        #1;
        chk("reset ready", req_ready, 0);
        chk("reset rsp", {rsp_valid, rsp_hit}, 0);
        chk("reset mem req", {mem_valid, mem_wb}, 0);
        chk("reset mem addr", mem_addr, 0);
        chk("reset ts en/we", {ts_en, ts_we}, 2'b11);
        step;
        rst_n = 1'b1;
        wait_init("init");
        bad = 0;
        for (int i = 0; i < 256; i++) bad += int'(mem[i] != '0);
        chk("init sweep zero", bad, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        mem_done = 1'b1;
        step;
        mem_done = 1'b0;
        #1;
        chk("stray done ready", req_ready, 1);
        chk("stray done quiet", {rsp_valid, mem_valid}, 0);

        req_valid = 1'b1;
        req_addr  = 64'hA000_2000;
        req_we    = 1'b0;
        step;
        req_valid = 1'b0;
        step;
        mem_ready = 1'b1;
        #1;
        chk("rst seq rf req", mem_valid, 1);
        chk("rst seq rf addr", mem_addr, 64'hA000_2000);
        step;
        mem_ready = 1'b0;
        #1;
        chk("rst seq rf wait", mem_valid, 0);
        rst_n = 1'b0;
        mem_done = 1'b1;
        step;
        mem_done = 1'b0;
        #1;
        chk("mid rst mem req", mem_valid, 0);
        chk("mid rst rsp", rsp_valid, 0);
        chk("mid rst ts en/we", {ts_en, ts_we}, 2'b11);
        chk("mid rst ready", req_ready, 0);
        step;
        rst_n = 1'b1;
        wait_init("reinit");
        chk("reinit idx4", mem[4], 0);
        chk("reinit idx0", mem[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
